bcd_count_ctrl: RTL and testbench

Run controller for a cascade of NUM_DIGITS BCD decade counters. It turns start/stop/clear commands and a preset-load handshake into a sequenced count. A prescaler sets the count rate, and the carry-enable chain feeds the digits. Terminal count is handled by either wrapping or halting. It sits between the user/control logic and the BCD digit datapath, and the packed digit vector goes to display logic.

---
 rtl/bcd_count_ctrl_pkg.sv | 26 ++
 rtl/bcd_count_ctrl_if.sv | 26 ++
 rtl/bcd_count_ctrl_digit.sv | 20 ++
 rtl/bcd_count_ctrl.sv | 101 ++++++++++
 tb/tb_bcd_count_ctrl.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/bcd_count_ctrl_pkg.sv
// Shared types and BCD helpers for the BCD run controller and its digit cells.
package bcd_count_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    // One-hot winner of the per-cycle command arbitration.
    typedef struct packed {
        logic clear;
        logic load;
        logic stop;
        logic start;
    } cmd_t;

    localparam int                 DIGIT_W   = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    // True when every one of the low num_digits nibbles is 0..9.
    function automatic logic is_valid_bcd(input logic [31:0] vec, input int num_digits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++)
            if (i < num_digits && vec[i*DIGIT_W +: DIGIT_W] > DIGIT_MAX) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/bcd_count_ctrl_if.sv
// Command, preset-load and status bundle between user logic and the BCD run controller.
interface bcd_count_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    start;
    logic                    stop;
    logic                    clear;
    logic                    load_valid;
    logic [4*NUM_DIGITS-1:0] load_data;
    logic                    load_ready;
    logic                    load_err;
    logic [4*NUM_DIGITS-1:0] Q_out;
    logic                    running;
    logic                    done;
    logic                    ovf;

    modport master (
        output start, stop, clear, load_valid, load_data,
        input  load_ready, load_err, Q_out, running, done, ovf
    );

    modport slave (
        input  start, stop, clear, load_valid, load_data,
        output load_ready, load_err, Q_out, running, done, ovf
    );
endinterface

// File: rtl/bcd_count_ctrl_digit.sv
// Single decade register: load beats increment; 9 rolls to 0 when incremented.
module bcd_digit
    import bcd_count_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_syn,
    input  logic               inc_en,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    output logic [DIGIT_W-1:0] q,
    output logic               is9
);
    assign is9 = (q == DIGIT_MAX);

    always_ff @(posedge clk) begin
        if (rst_syn)     q <= '0;
        else if (load)   q <= load_val;
        else if (inc_en) q <= is9 ? '0 : q + DIGIT_W'(1);
    end
endmodule

// File: rtl/bcd_count_ctrl.sv
// Run controller for a cascade of BCD digits: command FSM, prescaler and carry-enable chain.
module bcd_count_ctrl
    import bcd_count_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int PRESCALE    = 4,
    parameter int STOP_AT_MAX = 0
) (
    input  logic             clk,
    input  logic             rst_syn,
    bcd_count_ctrl_if.slave  bus
);
    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    localparam bit            HALT = (STOP_AT_MAX != 0);

    state_t                                 state, nxt;
    cmd_t                                   win;
    logic [PW-1:0]                          presc;
    logic                                   load_acc, bcd_ok, load_ok, load_bad;
    logic                                   step, terminal, dig_load;
    logic                                   ovf_q, err_q;
    logic [NUM_DIGITS-1:0]                  inc_en, is9;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]     q, ld_val;

    assign bus.load_ready = (state != RUN);
    assign load_acc       = bus.load_valid && bus.load_ready;
    assign bcd_ok         = is_valid_bcd(32'(bus.load_data), NUM_DIGITS);

    // Strict priority; whatever loses this cycle is dropped, not queued.
    always_comb begin
        win = '0;
        if (bus.clear)     win.clear = 1'b1;
        else if (load_acc) win.load  = 1'b1;
        else if (bus.stop) win.stop  = 1'b1;
        else if (bus.start) win.start = 1'b1;
    end

    assign load_ok  = win.load && bcd_ok;
    assign load_bad = win.load && !bcd_ok;
    assign step     = (state == RUN) && (presc == PMAX) && !win.clear;
    assign terminal = step && (&is9);
    assign dig_load = win.clear || load_ok;

    always_comb begin
        nxt = state;
        if (win.clear || load_ok) nxt = IDLE;
        else begin
            case (state)
                RUN: begin
                    if (terminal && HALT) nxt = DONE;
                    else if (win.stop)    nxt = PAUSE;
                end
                IDLE, PAUSE: if (win.start) nxt = RUN;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_syn) begin
            state <= IDLE;
            presc <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= nxt;
            ovf_q <= terminal && !HALT;
            err_q <= load_bad;
            // Phase is held outside RUN so a pause resumes mid-period.
            if (dig_load)            presc <= '0;
            else if (state == RUN)   presc <= (presc == PMAX) ? '0 : presc + PW'(1);
        end
    end

    // Halting at all-nines suppresses the step so the digits freeze at 9..9.
    assign inc_en[0] = step && !(terminal && HALT);

    for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_carry
        assign inc_en[k] = inc_en[k-1] && is9[k-1];
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        assign ld_val[k] = win.clear ? '0 : bus.load_data[k*DIGIT_W +: DIGIT_W];
        bcd_digit u_digit (
            .clk      (clk),
            .rst_syn  (rst_syn),
            .inc_en   (inc_en[k]),
            .load     (dig_load),
            .load_val (ld_val[k]),
            .q        (q[k]),
            .is9      (is9[k])
        );
    end

    assign bus.Q_out    = q;
    assign bus.running  = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.ovf      = ovf_q;
    assign bus.load_err = err_q;
endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed bench: two 2-digit, prescale-4 controllers (wrap and halt) driven in lockstep.
module tb_bcd_count_ctrl;
    logic       clk;
    logic       rst_syn;
    logic       start, stop, clear, load_valid;
    logic [7:0] load_data;
    int         checks;
    int         failures;

    bcd_count_ctrl_if #(.NUM_DIGITS(2)) if0 ();
    bcd_count_ctrl_if #(.NUM_DIGITS(2)) if1 ();

    assign if0.start = start;      assign if1.start = start;
    assign if0.stop  = stop;       assign if1.stop  = stop;
    assign if0.clear = clear;      assign if1.clear = clear;
    assign if0.load_valid = load_valid; assign if1.load_valid = load_valid;
    assign if0.load_data  = load_data;  assign if1.load_data  = load_data;

    bcd_count_ctrl #(.NUM_DIGITS(2), .PRESCALE(4), .STOP_AT_MAX(0)) dut0 (
        .clk(clk), .rst_syn(rst_syn), .bus(if0));
    bcd_count_ctrl #(.NUM_DIGITS(2), .PRESCALE(4), .STOP_AT_MAX(1)) dut1 (
        .clk(clk), .rst_syn(rst_syn), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_syn = 1'b1;
        tick; tick;
        rst_syn = 1'b0;
        checks++; if (if0.Q_out !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", if0.Q_out); end
        checks++; if (if0.load_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", if0.load_ready); end
        checks++; if ({if0.running, if0.done, if0.ovf, if0.load_err} !== 4'b0000)
            begin failures++; $display("FAIL reset_flags got=%b exp=0000", {if0.running, if0.done, if0.ovf, if0.load_err}); end
        checks++; if ({if1.Q_out, if1.running, if1.done} !== 10'h000)
            begin failures++; $display("FAIL reset_dut1 got=%h exp=000", {if1.Q_out, if1.running, if1.done}); end
    endtask

    task automatic test_count;
        start = 1'b1; tick; start = 1'b0;
        checks++; if (if0.running !== 1'b1) begin failures++; $display("FAIL count_running got=%b exp=1", if0.running); end
        for (int i = 1; i <= 3; i++) begin
            tick;
            checks++; if (if0.Q_out !== 8'h00) begin failures++; $display("FAIL count_hold0 edge=%0d got=%h exp=00", i, if0.Q_out); end
        end
        tick;
        checks++; if (if0.Q_out !== 8'h01) begin failures++; $display("FAIL count_first got=%h exp=01", if0.Q_out); end
        repeat (3) tick;
        checks++; if (if0.Q_out !== 8'h01) begin failures++; $display("FAIL count_hold1 got=%h exp=01", if0.Q_out); end
        tick;
        checks++; if (if0.Q_out !== 8'h02) begin failures++; $display("FAIL count_second got=%h exp=02", if0.Q_out); end
    endtask

    task automatic test_pause;
        tick;
        stop = 1'b1; tick; stop = 1'b0;
        checks++; if (if0.running !== 1'b0) begin failures++; $display("FAIL pause_state got=%b exp=0", if0.running); end
        for (int i = 0; i < 10; i++) begin
            tick;
            checks++; if (if0.Q_out !== 8'h02) begin failures++; $display("FAIL pause_hold cyc=%0d got=%h exp=02", i, if0.Q_out); end
        end
        start = 1'b1; tick; start = 1'b0;
        checks++; if (if0.running !== 1'b1) begin failures++; $display("FAIL resume_state got=%b exp=1", if0.running); end
        tick;
        checks++; if (if0.Q_out !== 8'h02) begin failures++; $display("FAIL resume_early got=%h exp=02", if0.Q_out); end
        tick;
        checks++; if (if0.Q_out !== 8'h03) begin failures++; $display("FAIL resume_step got=%h exp=03", if0.Q_out); end
        clear = 1'b1; tick; clear = 1'b0;
        checks++; if ({if0.Q_out, if0.running} !== 9'h000) begin failures++; $display("FAIL pause_clear got=%h exp=000", {if0.Q_out, if0.running}); end
    endtask

    task automatic test_wrap_halt;
        load_data = 8'h98; load_valid = 1'b1; tick; load_valid = 1'b0;
        checks++; if (if0.Q_out !== 8'h98 || if1.Q_out !== 8'h98)
            begin failures++; $display("FAIL preload got=%h/%h exp=98", if0.Q_out, if1.Q_out); end
        start = 1'b1; tick; start = 1'b0;
        repeat (4) tick;
        checks++; if (if0.Q_out !== 8'h99 || if1.Q_out !== 8'h99 || if1.running !== 1'b1)
            begin failures++; $display("FAIL to99 got=%h/%h run1=%b exp=99/99 1", if0.Q_out, if1.Q_out, if1.running); end
        repeat (4) tick;
        checks++; if (if0.Q_out !== 8'h00 || if0.ovf !== 1'b1 || if0.running !== 1'b1)
            begin failures++; $display("FAIL wrap got=%h ovf=%b run=%b exp=00 1 1", if0.Q_out, if0.ovf, if0.running); end
        checks++; if (if1.Q_out !== 8'h99 || if1.done !== 1'b1 || if1.running !== 1'b0 || if1.load_ready !== 1'b1 || if1.ovf !== 1'b0)
            begin failures++; $display("FAIL halt got=%h done=%b run=%b rdy=%b ovf=%b exp=99 1 0 1 0", if1.Q_out, if1.done, if1.running, if1.load_ready, if1.ovf); end
        tick;
        checks++; if (if0.ovf !== 1'b0 || if0.Q_out !== 8'h00) begin failures++; $display("FAIL ovf_pulse got ovf=%b q=%h exp=0 00", if0.ovf, if0.Q_out); end
        start = 1'b1; tick; start = 1'b0;
        checks++; if (if1.done !== 1'b1 || if1.running !== 1'b0 || if1.Q_out !== 8'h99)
            begin failures++; $display("FAIL done_start got done=%b run=%b q=%h exp=1 0 99", if1.done, if1.running, if1.Q_out); end
        clear = 1'b1; tick; clear = 1'b0;
        checks++; if (if1.done !== 1'b0 || if1.Q_out !== 8'h00 || if0.running !== 1'b0 || if0.Q_out !== 8'h00)
            begin failures++; $display("FAIL done_clear got done1=%b q1=%h run0=%b q0=%h exp=0 00 0 00", if1.done, if1.Q_out, if0.running, if0.Q_out); end
    endtask

    task automatic test_load_err;
        load_data = 8'h3A; load_valid = 1'b1; tick; load_valid = 1'b0;
        checks++; if (if0.load_err !== 1'b1 || if1.load_err !== 1'b1 || if0.Q_out !== 8'h00)
            begin failures++; $display("FAIL load_err got=%b/%b q=%h exp=1/1 00", if0.load_err, if1.load_err, if0.Q_out); end
        tick;
        checks++; if (if0.load_err !== 1'b0 || if0.running !== 1'b0) begin failures++; $display("FAIL load_err_pulse got err=%b run=%b exp=0 0", if0.load_err, if0.running); end
        start = 1'b1; tick; start = 1'b0;
        checks++; if (if0.load_ready !== 1'b0) begin failures++; $display("FAIL run_ready got=%b exp=0", if0.load_ready); end
        load_data = 8'h55; load_valid = 1'b1; tick; tick; load_valid = 1'b0;
        checks++; if (if0.Q_out !== 8'h00 || if0.running !== 1'b1 || if0.load_err !== 1'b0)
            begin failures++; $display("FAIL run_load got q=%h run=%b err=%b exp=00 1 0", if0.Q_out, if0.running, if0.load_err); end
    endtask

    task automatic test_priority;
        tick; tick;
        checks++; if (if0.Q_out !== 8'h01) begin failures++; $display("FAIL prio_pre got=%h exp=01", if0.Q_out); end
        clear = 1'b1; load_valid = 1'b1; load_data = 8'h45; start = 1'b1; tick;
        clear = 1'b0; load_valid = 1'b0; start = 1'b0;
        checks++; if (if0.Q_out !== 8'h00 || if0.running !== 1'b0 || if0.load_ready !== 1'b1)
            begin failures++; $display("FAIL prio_run got q=%h run=%b rdy=%b exp=00 0 1", if0.Q_out, if0.running, if0.load_ready); end
        load_data = 8'h12; load_valid = 1'b1; tick; load_valid = 1'b0;
        checks++; if (if0.Q_out !== 8'h12) begin failures++; $display("FAIL load_idle got=%h exp=12", if0.Q_out); end
        clear = 1'b1; load_valid = 1'b1; load_data = 8'h45; start = 1'b1; tick;
        clear = 1'b0; load_valid = 1'b0; start = 1'b0;
        checks++; if (if0.Q_out !== 8'h00 || if0.running !== 1'b0)
            begin failures++; $display("FAIL prio_idle got q=%h run=%b exp=00 0", if0.Q_out, if0.running); end
        load_data = 8'h37; load_valid = 1'b1; start = 1'b1; tick;
        load_valid = 1'b0; start = 1'b0;
        checks++; if (if0.Q_out !== 8'h37 || if0.running !== 1'b0)
            begin failures++; $display("FAIL load_over_start got q=%h run=%b exp=37 0", if0.Q_out, if0.running); end
    endtask

    task automatic test_reset_mid_run;
        start = 1'b1; tick; start = 1'b0;
        repeat (5) tick;
        checks++; if (if0.Q_out !== 8'h38) begin failures++; $display("FAIL mid_pre got=%h exp=38", if0.Q_out); end
        rst_syn = 1'b1; clear = 1'b1; tick; rst_syn = 1'b0; clear = 1'b0;
        checks++; if ({if0.Q_out, if0.running, if0.done, if0.ovf, if0.load_err, if0.load_ready} !== 13'h001)
            begin failures++; $display("FAIL mid_reset got=%h exp=001", {if0.Q_out, if0.running, if0.done, if0.ovf, if0.load_err, if0.load_ready}); end
        start = 1'b1; tick; start = 1'b0;
        repeat (3) tick;
        checks++; if (if0.Q_out !== 8'h00) begin failures++; $display("FAIL post_reset_hold got=%h exp=00", if0.Q_out); end
        tick;
        checks++; if (if0.Q_out !== 8'h01) begin failures++; $display("FAIL post_reset_step got=%h exp=01", if0.Q_out); end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_syn = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
        load_valid = 1'b0; load_data = 8'h00;
        #2;
        test_reset;
        test_count;
        test_pause;
        test_wrap_halt;
        test_load_err;
        test_priority;
        test_reset_mid_run;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
